// File: rtl/fetch_d.sv
// Fetch stage with F/D pipeline register: PC sequencing, redirect, stall/flush
// handling, a sticky misaligned-target flag and a saturating wait-cycle counter.
module fetch_d #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] ImemRdata,
  input  logic        ImemReady,
  output logic [31:0] PCF,
  output logic        ImemReq,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignErr,
  output logic [15:0] WaitCount
);

  typedef enum logic [1:0] {
    FD_LOAD,
    FD_HOLD,
    FD_BUBBLE
  } fd_op_t;

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  fd_op_t      fd_op;
  logic        wait_cycle;

  assign pc_plus4   = PCF + 32'd4;
  assign ImemReq    = ~reset;
  assign wait_cycle = ~ImemReady & ~PCSrcE;

  always_comb begin
    pc_next = PCF;
    if (PCSrcE)
      pc_next = {PCTargetE[31:2], 2'b00};
    else if (StallF || !ImemReady)
      pc_next = PCF;
    else
      pc_next = pc_plus4;
  end

  // A redirect squashes the word in flight even when decode is stalled.
  always_comb begin
    fd_op = FD_LOAD;
    if (FlushD || PCSrcE)
      fd_op = FD_BUBBLE;
    else if (StallD)
      fd_op = FD_HOLD;
    else if (!ImemReady)
      fd_op = FD_BUBBLE;
    else
      fd_op = FD_LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PCF         <= RESET_PC;
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
      ValidD      <= 1'b0;
      MisalignErr <= 1'b0;
      WaitCount   <= '0;
    end else begin
      PCF <= pc_next;

      case (fd_op)
        FD_BUBBLE: begin
          InstrD   <= NOP_INSTR;
          PCD      <= '0;
          PCPlus4D <= '0;
          ValidD   <= 1'b0;
        end
        FD_LOAD: begin
          InstrD   <= ImemRdata;
          PCD      <= PCF;
          PCPlus4D <= pc_plus4;
          ValidD   <= 1'b1;
        end
        default: ;
      endcase

      if (PCSrcE && (PCTargetE[1:0] != 2'b00))
        MisalignErr <= 1'b1;

      if (wait_cycle && (WaitCount != '1))
        WaitCount <= WaitCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_d.sv
// Bench for fetch_d: directed vector table, random run against a reference
// model, and counter saturation / reset-abandon sequences.
module tb_fetch_d;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF, StallD, FlushD;
  logic [31:0] ImemRdata;
  logic        ImemReady;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ImemReq, ValidD, MisalignErr;
  logic [15:0] WaitCount;

  int unsigned total = 0;
  int unsigned bad   = 0;

  fetch_d #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ImemRdata(ImemRdata), .ImemReady(ImemReady),
    .PCF(PCF), .ImemReq(ImemReq), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignErr(MisalignErr),
    .WaitCount(WaitCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, src;
    logic [31:0] tgt;
    logic        sf, sd, fd, rdy;
    logic [31:0] rd;
    logic [31:0] e_pcf, e_instr, e_pcd, e_p4;
    logic        e_valid, e_mis;
    logic [15:0] e_wait;
  } vec_t;

  function automatic vec_t mk(logic rst, logic src, logic [31:0] tgt, logic sf,
                              logic sd, logic fd, logic rdy, logic [31:0] rd,
                              logic [31:0] e_pcf, logic [31:0] e_instr,
                              logic [31:0] e_pcd, logic [31:0] e_p4,
                              logic e_valid, logic e_mis, logic [15:0] e_wait);
    vec_t v;
    v.rst = rst; v.src = src; v.tgt = tgt; v.sf = sf; v.sd = sd; v.fd = fd;
    v.rdy = rdy; v.rd = rd; v.e_pcf = e_pcf; v.e_instr = e_instr;
    v.e_pcd = e_pcd; v.e_p4 = e_p4; v.e_valid = e_valid; v.e_mis = e_mis;
    v.e_wait = e_wait;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(logic rst, logic src, logic [31:0] tgt, logic sf,
                      logic sd, logic fd, logic rdy, logic [31:0] rd);
    reset = rst; PCSrcE = src; PCTargetE = tgt; StallF = sf; StallD = sd;
    FlushD = fd; ImemReady = rdy; ImemRdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic [31:0] e_pcf, logic [31:0] e_instr,
                           logic [31:0] e_pcd, logic [31:0] e_p4, logic e_valid,
                           logic e_mis, logic [15:0] e_wait, logic e_req);
    chk({tag, ".PCF"}, PCF, e_pcf);
    chk({tag, ".InstrD"}, InstrD, e_instr);
    chk({tag, ".PCD"}, PCD, e_pcd);
    chk({tag, ".PCPlus4D"}, PCPlus4D, e_p4);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, e_valid});
    chk({tag, ".MisalignErr"}, {31'd0, MisalignErr}, {31'd0, e_mis});
    chk({tag, ".WaitCount"}, {16'd0, WaitCount}, {16'd0, e_wait});
    chk({tag, ".ImemReq"}, {31'd0, ImemReq}, {31'd0, e_req});
  endtask

  // Reference model: pipeline state as plain values, wait count as an integer.
  logic [31:0] m_pc, m_instr, m_pcd, m_p4;
  logic        m_valid, m_mis;
  int unsigned m_wait;

  task automatic model(logic rst, logic src, logic [31:0] tgt, logic sf,
                       logic sd, logic fd, logic rdy, logic [31:0] rd);
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_p4 = 0;
      m_valid = 0; m_mis = 0; m_wait = 0;
      return;
    end
    if (src) m_pc = tgt & 32'hFFFF_FFFC;
    else if (!sf && rdy) m_pc = old_pc + 32'd4;
    if (fd || src || (!sd && !rdy)) begin
      m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_valid = 0;
    end else if (!sd) begin
      m_instr = rd; m_pcd = old_pc; m_p4 = old_pc + 32'd4; m_valid = 1;
    end
    if (src && (tgt % 4 != 0)) m_mis = 1;
    if (!rdy && !src && m_wait < 65535) m_wait++;
  endtask

  vec_t vecs[17];

  initial begin
    // Directed table: each row is one cycle of inputs and the state after the edge.
    vecs[0]  = mk(1,0,0,0,0,0,0,0,           0,'h13,0,0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0,0,1,'hA0,        4,'hA0,0,4,1,0,0);
    vecs[2]  = mk(0,0,0,0,0,0,1,'hA1,        8,'hA1,4,8,1,0,0);
    vecs[3]  = mk(0,0,0,0,0,0,0,'hEE,        8,'h13,0,0,0,0,1);
    vecs[4]  = mk(0,0,0,0,0,0,0,'hEE,        8,'h13,0,0,0,0,2);
    vecs[5]  = mk(0,0,0,0,0,0,0,'hEE,        8,'h13,0,0,0,0,3);
    vecs[6]  = mk(0,0,0,0,0,0,1,'hA2,        'hC,'hA2,8,'hC,1,0,3);
    vecs[7]  = mk(0,0,0,1,1,0,1,'hA3,        'hC,'hA2,8,'hC,1,0,3);
    vecs[8]  = mk(0,0,0,1,1,0,1,'hA3,        'hC,'hA2,8,'hC,1,0,3);
    vecs[9]  = mk(0,0,0,1,0,1,1,'hA3,        'hC,'h13,0,0,0,0,3);
    vecs[10] = mk(0,1,'h100,1,0,0,0,'hEE,    'h100,'h13,0,0,0,0,3);
    vecs[11] = mk(0,1,'h202,0,0,0,1,'hEE,    'h200,'h13,0,0,0,1,3);
    vecs[12] = mk(0,0,0,0,0,0,1,'hA4,        'h204,'hA4,'h200,'h204,1,1,3);
    vecs[13] = mk(0,1,'h8,0,0,0,1,'hEE,      'h8,'h13,0,0,0,1,3);
    vecs[14] = mk(0,1,'hFFFF_FFFC,0,1,0,0,0, 'hFFFF_FFFC,'h13,0,0,0,1,3);
    vecs[15] = mk(0,0,0,0,0,0,1,'hA5,        0,'hA5,'hFFFF_FFFC,0,1,1,3);
    vecs[16] = mk(1,1,'h40,1,1,0,0,0,        0,'h13,0,0,0,0,0);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].src, vecs[i].tgt, vecs[i].sf, vecs[i].sd,
           vecs[i].fd, vecs[i].rdy, vecs[i].rd);
      check_all($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_instr,
                vecs[i].e_pcd, vecs[i].e_p4, vecs[i].e_valid, vecs[i].e_mis,
                vecs[i].e_wait, ~vecs[i].rst);
    end

    // Random run against the model, starting from reset.
    model(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic r_rst, r_src, r_sf, r_sd, r_fd, r_rdy;
      logic [31:0] r_tgt, r_rd;
      r_rst = ($urandom_range(0, 79) == 0);
      r_src = ($urandom_range(0, 9) == 0);
      r_sf  = ($urandom_range(0, 5) == 0);
      r_sd  = r_sf & ($urandom_range(0, 1) == 1);
      r_fd  = ($urandom_range(0, 11) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_tgt = $urandom;
      if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
      r_rd  = $urandom;
      model(r_rst, r_src, r_tgt, r_sf, r_sd, r_fd, r_rdy, r_rd);
      step(r_rst, r_src, r_tgt, r_sf, r_sd, r_fd, r_rdy, r_rd);
      if (i % 8 == 0 || PCF !== m_pc || ValidD !== m_valid)
        check_all($sformatf("rnd%0d", i), m_pc, m_instr, m_pcd, m_p4, m_valid,
                  m_mis, m_wait[15:0], ~r_rst);
    end

    // Saturation of the wait counter, then reset in the middle of a stall.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wait_preload", {16'd0, WaitCount}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, 0);
      chk($sformatf("wait_sat%0d", i), {16'd0, WaitCount}, 32'h0000_FFFF);
    end
    step(0, 1, 'h80, 0, 0, 0, 0, 0);
    chk("wait_redirect_frozen", {16'd0, WaitCount}, 32'h0000_FFFF);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    check_all("rst_midstall", 0, 'h13, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 'hB0);
    check_all("first_fetch", 4, 'hB0, 0, 4, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_d.md
FETCH_D -- requirements
Module: fetch_d

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002: Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL set the bubble instruction.
REQ-003: clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005: PCSrcE  input  1  execute-stage redirect (taken branch or jump).
REQ-006: PCTargetE  input  32  redirect target address.
REQ-007: StallF  input  1  hazard-unit hold of PCF.
REQ-008: StallD  input  1  hazard-unit hold of F/D register.
REQ-009: FlushD  input  1  hazard-unit bubble into F/D register.
REQ-010: ImemRdata  input  32  instruction word for address PCF, valid when ImemReady=1.
REQ-011: ImemReady  input  1  instruction memory returns ImemRdata this cycle.
REQ-012: PCF  output  32  fetch address to instruction memory (registered).
REQ-013: ImemReq  output  1  fetch request; SHALL equal ~reset.
REQ-014: InstrD  output  32  decode-stage instruction (registered).
REQ-015: PCD  output  32  PC of InstrD (registered).
REQ-016: PCPlus4D  output  32  PCD+4 (registered).
REQ-017: ValidD  output  1  InstrD is a real fetched instruction, not a bubble.
REQ-018: MisalignErr  output  1  sticky flag: redirect target had nonzero bits [1:0].
REQ-019: WaitCount  output  16  saturating count of cycles with ImemReady=0 and no redirect.

Function
REQ-020: Next PCF SHALL be chosen by priority: PCSrcE -> {PCTargetE[31:2],2'b00}; else StallF=1 or ImemReady=0 -> hold; else PCF+4.
REQ-021: PCF+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-022: F/D register priority SHALL be: FlushD=1 or PCSrcE=1 -> bubble; else StallD=1 -> hold all F/D outputs; else ImemReady=0 -> bubble; else load.
REQ-023: Bubble SHALL set InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-024: Load SHALL set InstrD=ImemRdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
REQ-025: Latency: instruction accepted at PCF in cycle N SHALL appear on InstrD in cycle N+1.
REQ-026: PCSrcE SHALL override StallF, StallD and ImemReady=0 in the same cycle; the word on ImemRdata that cycle SHALL be discarded.
REQ-027: StallD=1 with StallF=0 and ImemReady=1 SHALL still advance PCF (hazard unit guarantees this combination does not occur; no checking).
REQ-028: When PCSrcE=1 and PCTargetE[1:0]!=0, MisalignErr SHALL set next cycle and remain 1 until reset.
REQ-029: WaitCount SHALL increment when ImemReady=0 and PCSrcE=0, saturate at 16'hFFFF, never wrap.
REQ-030: All outputs except ImemReq SHALL be driven only from registers.

Reset
REQ-031: On reset=1 at posedge clk: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignErr=0, WaitCount=0.
REQ-032: Reset SHALL override PCSrcE, StallF, StallD, FlushD and ImemReady in the same cycle.
REQ-033: Reset asserted mid-stall or mid-redirect SHALL abandon the operation; first fetch after release SHALL be at RESET_PC.
REQ-034: ImemReq SHALL be 0 while reset=1.

Verification
REQ-035: Reset, then ImemReady=1, no stalls, 3 cycles -> PCF 0,4,8,12; InstrD follows ImemRdata one cycle later, PCD 0,4,8, ValidD=1.
REQ-036: PCF=32'h10, PCSrcE=1, PCTargetE=32'h100, StallF=1, ImemReady=0 -> next cycle PCF=32'h100, InstrD=32'h13, ValidD=0, WaitCount unchanged.
REQ-037: ImemReady=0 for 3 cycles at PCF=32'h8 -> PCF holds 32'h8, ValidD=0 each cycle, WaitCount +3; ImemReady=1 -> PCF=32'hC, PCD=32'h8.
REQ-038: StallF=1, StallD=1 for 2 cycles with PCD=32'h4 -> PCF, InstrD, PCD, ValidD all held; FlushD=1 next -> ValidD=0, InstrD=32'h13.
REQ-039: PCSrcE=1, PCTargetE=32'h202 -> PCF=32'h200, MisalignErr=1 and held across later redirects; PCF=32'hFFFF_FFFC advance -> PCF=32'h0.
REQ-040: WaitCount preloaded to 16'hFFFE via stalls, 3 more not-ready cycles -> stays 16'hFFFF; reset during stall -> PCF=RESET_PC, WaitCount=0.
